// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with one-entry skid buffer and branch drain
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] inst_out_o,
    output logic [31:0] pc_out_o,
    output logic        valid_out_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    logic        req_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] inst_q;
    logic [31:0] pc_out_q;
    logic        valid_q;
    logic        skid_valid_q;
    logic [31:0] skid_inst_q;
    logic [31:0] skid_pc_q;

    logic [31:0] target_aligned;
    logic [31:0] pc_next;
    logic        out_free;

    // Redirect targets are word aligned; the low two bits are simply dropped.
    assign target_aligned = branch_target_i & 32'hFFFF_FFFC;
    // Sequential PC wraps modulo 2^32.
    assign pc_next        = pc_q + PC_STEP;
    // Output register can take a new word if it is empty or decode consumes it now.
    assign out_free       = !valid_q || !stall_i;

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign inst_out_o  = inst_q;
    assign pc_out_o    = pc_out_q;
    assign valid_out_o = valid_q;

    // Fetch FSM: PC, memory request, output register and skid buffer all update here.
    // addr_q follows the PC except in DRAIN, where it keeps the abandoned address
    // on the bus until memory acknowledges it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            req_q        <= 1'b0;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            inst_q       <= 32'h0;
            pc_out_q     <= 32'h0;
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_inst_q  <= 32'h0;
            skid_pc_q    <= 32'h0;
        end else if (branch_taken_i) begin
            // Redirect wins over stall and ack: flush output and skid, retarget PC.
            valid_q      <= 1'b0;
            skid_valid_q <= 1'b0;
            pc_q         <= target_aligned;
            case (state_q)
                S_FETCH: begin
                    req_q <= 1'b1;
                    if (imem_ack_i) begin
                        state_q <= S_FETCH;
                        addr_q  <= target_aligned;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    req_q <= 1'b1;
                    if (imem_ack_i) begin
                        state_q <= S_FETCH;
                        addr_q  <= target_aligned;
                    end else begin
                        state_q <= S_DRAIN;
                    end
                end
                default: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= target_aligned;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= pc_q;
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        pc_q   <= pc_next;
                        addr_q <= pc_next;
                        if (out_free) begin
                            inst_q   <= imem_data_i;
                            pc_out_q <= pc_q;
                            valid_q  <= 1'b1;
                            state_q  <= S_FETCH;
                            req_q    <= 1'b1;
                        end else begin
                            skid_inst_q  <= imem_data_i;
                            skid_pc_q    <= pc_q;
                            skid_valid_q <= 1'b1;
                            state_q      <= S_WAIT;
                            req_q        <= 1'b0;
                        end
                    end else if (!stall_i) begin
                        valid_q <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (!stall_i) begin
                        inst_q       <= skid_inst_q;
                        pc_out_q     <= skid_pc_q;
                        valid_q      <= skid_valid_q;
                        skid_valid_q <= 1'b0;
                        state_q      <= S_FETCH;
                        req_q        <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (!stall_i) begin
                        valid_q <= 1'b0;
                    end
                    if (imem_ack_i) begin
                        state_q <= S_FETCH;
                        req_q   <= 1'b1;
                        addr_q  <= pc_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed self-checking bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        valid_out;

    int checks;
    int failures;

    if_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .imem_data_i     (imem_data),
        .inst_out_o      (inst_out),
        .pc_out_o        (pc_out),
        .valid_out_o     (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns address + 0x100 for whatever is on the bus.
    always @* imem_data = imem_addr + 32'h100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0; imem_ack = 1'b1;
        tick(); tick();
        checks++;
        if ({imem_req, valid_out, inst_out, pc_out, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_state req=%0b valid=%0b inst=%h pc=%h addr=%h expected all zero",
                     imem_req, valid_out, inst_out, pc_out, imem_addr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || valid_out !== 1'b0 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_first_fetch req=%0b valid=%0b addr=%h expected req=1 valid=0 addr=0",
                     imem_req, valid_out, imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'(4 * i) || inst_out !== 32'(32'h100 + 4 * i)) begin
                failures++;
                $display("FAIL stream_%0d valid=%0b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                         i, valid_out, pc_out, inst_out, 4 * i, 32'h100 + 4 * i);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'h10 || inst_out !== 32'h110 || imem_req !== 1'b0) begin
                failures++;
                $display("FAIL stall_hold_%0d valid=%0b pc=%h inst=%h req=%0b expected valid=1 pc=10 inst=110 req=0",
                         i, valid_out, pc_out, inst_out, imem_req);
            end
        end
        stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'(32'h14 + 4 * i) || inst_out !== 32'(32'h114 + 4 * i)) begin
                failures++;
                $display("FAIL stall_resume_%0d valid=%0b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                         i, valid_out, pc_out, inst_out, 32'h14 + 4 * i, 32'h114 + 4 * i);
            end
        end
    endtask

    task automatic test_latency();
        for (int k = 0; k < 2; k++) begin
            imem_ack = 1'b0;
            for (int w = 0; w < 2; w++) begin
                tick();
                checks++;
                if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'(32'h20 + 4 * k)) begin
                    failures++;
                    $display("FAIL latency_wait_%0d_%0d valid=%0b req=%0b addr=%h expected valid=0 req=1 addr=%h",
                             k, w, valid_out, imem_req, imem_addr, 32'h20 + 4 * k);
                end
            end
            imem_ack = 1'b1;
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== 32'(32'h20 + 4 * k) || inst_out !== 32'(32'h120 + 4 * k)) begin
                failures++;
                $display("FAIL latency_done_%0d valid=%0b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                         k, valid_out, pc_out, inst_out, 32'h20 + 4 * k, 32'h120 + 4 * k);
            end
        end
    endtask

    task automatic test_branch_drain();
        imem_ack = 1'b0;
        tick();
        branch_taken = 1'b1; branch_target = 32'h203;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h28 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL drain_enter req=%0b addr=%h valid=%0b expected req=1 addr=28 valid=0",
                     imem_req, imem_addr, valid_out);
        end
        tick();
        checks++;
        if (imem_addr !== 32'h28 || valid_out !== 1'b0) begin
            failures++;
            $display("FAIL drain_hold addr=%h valid=%0b expected addr=28 valid=0", imem_addr, valid_out);
        end
        imem_ack = 1'b1;
        tick();
        checks++;
        if (imem_addr !== 32'h200 || valid_out !== 1'b0 || imem_req !== 1'b1) begin
            failures++;
            $display("FAIL drain_discard addr=%h valid=%0b req=%0b expected addr=200 valid=0 req=1",
                     imem_addr, valid_out, imem_req);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h200 || inst_out !== 32'h300) begin
            failures++;
            $display("FAIL drain_refetch valid=%0b pc=%h inst=%h expected valid=1 pc=200 inst=300",
                     valid_out, pc_out, inst_out);
        end
    endtask

    task automatic test_branch_ack();
        branch_taken = 1'b1; branch_target = 32'h1000;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || imem_addr !== 32'h1000) begin
            failures++;
            $display("FAIL branch_ack_flush valid=%0b addr=%h expected valid=0 addr=1000", valid_out, imem_addr);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h1000 || inst_out !== 32'h1100) begin
            failures++;
            $display("FAIL branch_ack_target valid=%0b pc=%h inst=%h expected valid=1 pc=1000 inst=1100",
                     valid_out, pc_out, inst_out);
        end
    endtask

    task automatic test_branch_stall();
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h2000;
        tick();
        stall = 1'b0; branch_taken = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || imem_addr !== 32'h2000) begin
            failures++;
            $display("FAIL branch_stall_flush valid=%0b addr=%h expected valid=0 addr=2000", valid_out, imem_addr);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h2000 || inst_out !== 32'h2100) begin
            failures++;
            $display("FAIL branch_stall_target valid=%0b pc=%h inst=%h expected valid=1 pc=2000 inst=2100",
                     valid_out, pc_out, inst_out);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [3];
        logic [31:0] exp_inst [3];
        exp_pc   = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        exp_inst = '{32'h0000_00F8, 32'h0000_00FC, 32'h0000_0100};
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFF8;
        tick();
        branch_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (valid_out !== 1'b1 || pc_out !== exp_pc[i] || inst_out !== exp_inst[i]) begin
                failures++;
                $display("FAIL wrap_%0d valid=%0b pc=%h inst=%h expected valid=1 pc=%h inst=%h",
                         i, valid_out, pc_out, inst_out, exp_pc[i], exp_inst[i]);
            end
        end
    endtask

    task automatic test_wait_branch();
        stall = 1'b1;
        tick();
        checks++;
        if (imem_req !== 1'b0 || valid_out !== 1'b1 || pc_out !== 32'h0) begin
            failures++;
            $display("FAIL wait_enter req=%0b valid=%0b pc=%h expected req=0 valid=1 pc=0",
                     imem_req, valid_out, pc_out);
        end
        branch_taken = 1'b1; branch_target = 32'h400;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        checks++;
        if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin
            failures++;
            $display("FAIL wait_branch valid=%0b req=%0b addr=%h expected valid=0 req=1 addr=400",
                     valid_out, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h400 || inst_out !== 32'h500) begin
            failures++;
            $display("FAIL wait_branch_target valid=%0b pc=%h inst=%h expected valid=1 pc=400 inst=500",
                     valid_out, pc_out, inst_out);
        end
    endtask

    task automatic test_reset_mid();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if ({imem_req, valid_out, inst_out, pc_out, imem_addr} !== {1'b0, 1'b0, 32'h0, 32'h0, 32'h0}) begin
            failures++;
            $display("FAIL reset_async req=%0b valid=%0b inst=%h pc=%h addr=%h expected all zero",
                     imem_req, valid_out, inst_out, pc_out, imem_addr);
        end
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (valid_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL reset_ack_ignored valid=%0b req=%0b addr=%h expected valid=0 req=1 addr=0",
                     valid_out, imem_req, imem_addr);
        end
        tick();
        checks++;
        if (valid_out !== 1'b1 || pc_out !== 32'h0 || inst_out !== 32'h100) begin
            failures++;
            $display("FAIL reset_refetch valid=%0b pc=%h inst=%h expected valid=1 pc=0 inst=100",
                     valid_out, pc_out, inst_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_stream();
        test_stall();
        test_latency();
        test_branch_drain();
        test_branch_ack();
        test_branch_stall();
        test_wrap();
        test_wait_branch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 Parameter PC_STEP, default 4, SHALL be the sequential PC increment.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Stall  input  1  SHALL mean the downstream decode stage cannot accept Inst_Out this cycle.
REQ-006 Branch_Taken  input  1  SHALL mean redirect fetch to Branch_Target and flush in-flight work.
REQ-007 Branch_Target  input  32  SHALL be the redirect address; bits [1:0] are forced to 0 internally.
REQ-008 Imem_Req  output  1  SHALL be the instruction memory read request.
REQ-009 Imem_Addr  output  32  SHALL be the fetch address; equals internal PC.
REQ-010 Imem_Ack  input  1  SHALL mean Imem_Data is valid and completes the pending request.
REQ-011 Imem_Data  input  32  SHALL be the instruction word returned by memory.
REQ-012 Inst_Out  output  32  SHALL be the registered instruction presented to decode (drives decode Inst_In).
REQ-013 PC_Out  output  32  SHALL be the registered address of Inst_Out.
REQ-014 Valid_Out  output  1  SHALL mean Inst_Out/PC_Out hold a live instruction.

Function
REQ-015 FSM states SHALL be IDLE, FETCH, WAIT, DRAIN; Imem_Req SHALL be 1 exactly in FETCH and DRAIN.
REQ-016 IDLE SHALL go to FETCH on the first edge after Rst deasserts.
REQ-017 Imem_Addr SHALL stay stable while Imem_Req=1 and Imem_Ack=0.
REQ-018 FETCH, Ack=1, output register free (Valid_Out=0 or Stall=0): Inst_Out<=Imem_Data, PC_Out<=PC, Valid_Out<=1, PC<=PC+PC_STEP, stay FETCH.
REQ-019 FETCH, Ack=1, Valid_Out=1 and Stall=1: data and PC SHALL go to a one-entry skid buffer, PC<=PC+PC_STEP, go to WAIT.
REQ-020 WAIT: when Stall=0, skid contents SHALL load Inst_Out/PC_Out with Valid_Out=1, skid clears, go to FETCH.
REQ-021 Stall=0 with no new instruction loaded SHALL clear Valid_Out next edge; Stall=1 SHALL hold Inst_Out, PC_Out, Valid_Out unchanged.
REQ-022 With single-cycle memory (Ack in the same cycle as Req) and Stall=0, throughput SHALL be one instruction per cycle; latency from Req to Valid_Out SHALL be one edge.
REQ-023 Branch_Taken=1 SHALL take priority over Stall and Ack: Valid_Out<=0, skid cleared, PC<={Branch_Target[31:2],2'b00}.
REQ-024 Branch in FETCH with Ack=1 SHALL discard Imem_Data and stay FETCH at the new PC.
REQ-025 Branch in FETCH with Ack=0 SHALL go to DRAIN, keeping Req and the old address held.
REQ-026 DRAIN: the next Ack SHALL be discarded (no output, no PC step), then go to FETCH; a further branch in DRAIN SHALL only update PC.
REQ-027 Branch in IDLE or WAIT SHALL go to FETCH at the new PC.
REQ-028 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-029 Rst=1 SHALL asynchronously force PC=RESET_PC, state=IDLE, Inst_Out=0, PC_Out=0, Valid_Out=0, skid empty, Imem_Req=0.
REQ-030 Reset mid-request SHALL abandon it; any Ack during Rst or the first post-reset cycle SHALL be ignored.

Verification
REQ-031 Reset release, Ack tied 1, memory returns addr+0x100 -> Valid_Out=1 from cycle 2, PC_Out 0,4,8,..., Inst_Out 0x100,0x104,...
REQ-032 Stall=1 for 3 cycles with Ack=1 -> Inst_Out held, skid captures next word, Req=0 in WAIT; Stall=0 -> outputs continue with no gap or loss.
REQ-033 Memory latency 3 cycles -> Imem_Addr constant during wait, Valid_Out pulses once per completed fetch.
REQ-034 Branch_Taken with target 0x203 while Ack pending -> DRAIN, stale word dropped, next fetch address 0x200, PC_Out=0x200.
REQ-035 Branch_Taken and Stall both 1 with Valid_Out=1 -> Valid_Out=0 next edge.
REQ-036 Rst asserted mid-FETCH -> all outputs 0 immediately, refetch from RESET_PC.
